// File: rtl/serial_adder_pipe_if.sv
// Request/result bundle for serial_adder_pipe.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps
interface serial_adder_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_pipe.sv
// Multi-cycle adder: BITS_PER_CYCLE full-adder cells per clock with a registered carry.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (a + ~b + 1) selected by bus.sub.
`timescale 1ns/1ps
module serial_adder_pipe #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_pipe_if.slave  bus
);
    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned BPC   = BITS_PER_CYCLE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder_pipe: WIDTH must be at least 2");
        end
        if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
            $error("serial_adder_pipe: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [BPC-1:0]   slice_sum;
    logic             slice_cout;
    logic             c;

    // Subtraction is folded into capture: invert B and force the carry-in.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    // Ripple chain of full-adder cells over the low slice of the operand shifters.
    always_comb begin
        slice_sum = '0;
        c         = carry_q;
        for (int i = 0; i < int'(BPC); i++) begin
            slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_cout = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        psum_d  = psum_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = b_in;
                    carry_d = c_in;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = slice_cout;
                psum_d  = (psum_q >> BPC) | (WIDTH'(slice_sum) << (WIDTH - BPC));
                cnt_d   = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    sum_d   = psum_d;
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_pipe.sv
// Bench for serial_adder_pipe: instances at (8,1), (8,4) and (3,1) against an arithmetic model.
// Honours SERIAL_ADDER_SUB_EN the same way the design does.
`timescale 1ns/1ps
module tb_serial_adder_pipe;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    serial_adder_pipe_if #(.WIDTH(8)) bus0 ();
    serial_adder_pipe_if #(.WIDTH(8)) bus1 ();
    serial_adder_pipe_if #(.WIDTH(3)) bus2 ();

    serial_adder_pipe #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_adder_pipe #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder_pipe #(.WIDTH(3), .BITS_PER_CYCLE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic       b2b;
        int         glitch;
        logic [7:0] es;
        logic       ec;
        int         el;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int sel, logic [7:0] a, logic [7:0] b, logic ci, logic sb,
                                logic b2b, int glitch, logic [7:0] es, logic ec, int el);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.ci = ci; v.sb = sb; v.b2b = b2b;
        v.glitch = glitch; v.es = es; v.ec = ec; v.el = el;
        return v;
    endfunction

    // Reference: plain integer arithmetic at width w, returning {cout,sum} packed as an int.
    function automatic int unsigned model(int w, logic [7:0] a, logic [7:0] b, logic ci, logic sb);
        int unsigned m = (32'd1 << w) - 1;
        int unsigned ua = 32'(a) & m;
        int unsigned ub = 32'(b) & m;
        if (sb) return ua + ((~ub) & m) + 1;
        return ua + ub + 32'(ci);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(int sel, logic st, logic [7:0] a, logic [7:0] b, logic ci, logic sb);
        case (sel)
            0: begin
                bus0.start = st; bus0.a = a; bus0.b = b; bus0.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                bus0.sub = sb;
`endif
            end
            1: begin
                bus1.start = st; bus1.a = a; bus1.b = b; bus1.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                bus1.sub = sb;
`endif
            end
            default: begin
                bus2.start = st; bus2.a = 3'(a); bus2.b = 3'(b); bus2.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                bus2.sub = sb;
`endif
            end
        endcase
    endtask

    function automatic logic get_done(int sel);
        case (sel)
            0: return bus0.done;
            1: return bus1.done;
            default: return bus2.done;
        endcase
    endfunction

    function automatic logic get_busy(int sel);
        case (sel)
            0: return bus0.busy;
            1: return bus1.busy;
            default: return bus2.busy;
        endcase
    endfunction

    function automatic logic [7:0] get_sum(int sel);
        case (sel)
            0: return bus0.sum;
            1: return bus1.sum;
            default: return 8'(bus2.sum);
        endcase
    endfunction

    function automatic logic get_cout(int sel);
        case (sel)
            0: return bus0.cout;
            1: return bus1.cout;
            default: return bus2.cout;
        endcase
    endfunction

    // One operation; ends sampling at the negedge of the done cycle. Inputs are scrambled after acceptance.
    task automatic do_op(int sel, logic [7:0] a, logic [7:0] b, logic ci, logic sb, logic b2b,
                         int glitch, output logic [7:0] s, output logic co,
                         output int lat, output int bsy);
        logic got;
        if (!b2b) @(negedge clk);
        drive(sel, 1'b1, a, b, ci, sb);
        @(posedge clk);
        @(negedge clk);
        lat = 0; bsy = 0; got = 1'b0;
        while (!got && lat < 64) begin
            if (lat == glitch) drive(sel, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
            else drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if (get_busy(sel)) bsy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = get_done(sel);
        end
        drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        if (!got) chk($sformatf("timeout_sel%0d", sel), 32'(got), 32'd1);
        s  = get_sum(sel);
        co = get_cout(sel);
    endtask

    initial begin
        logic [7:0]  s;
        logic        co;
        int          lat, bsy, steps;
        int unsigned r;
        logic        seen;
        n_pass = 0; n_total = 0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_sum",  32'(bus0.sum),  32'd0);
        chk("rst_cout", 32'(bus0.cout), 32'd0);
        #11 rst_n = 1'b1;

        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, -1, 8'h00, 0, 8));
        vecs.push_back(mk(0, 8'hFF, 8'h01, 0, 0, 0, -1, 8'h00, 1, 8));
        vecs.push_back(mk(0, 8'hA5, 8'h5A, 1, 0, 1, -1, 8'h00, 1, 8));
        vecs.push_back(mk(1, 8'h3C, 8'h47, 0, 0, 0, -1, 8'h83, 0, 2));
        vecs.push_back(mk(1, 8'hFF, 8'hFF, 1, 0, 0, -1, 8'hFF, 1, 2));
        vecs.push_back(mk(0, 8'h12, 8'h34, 0, 0, 0,  3, 8'h46, 0, 8));
        vecs.push_back(mk(1, 8'h80, 8'h7F, 1, 0, 1, -1, 8'h00, 1, 2));
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back(mk(0, 8'h10, 8'h01, 0, 1, 0, -1, 8'h0F, 1, 8));
        vecs.push_back(mk(0, 8'h01, 8'h02, 1, 1, 0, -1, 8'hFF, 0, 8));
        vecs.push_back(mk(1, 8'h80, 8'h80, 0, 1, 0, -1, 8'h00, 1, 2));
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].b2b,
                  vecs[i].glitch, s, co, lat, bsy);
            chk($sformatf("vec%0d_sum", i),  32'(s),   32'(vecs[i].es));
            chk($sformatf("vec%0d_cout", i), 32'(co),  32'(vecs[i].ec));
            chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].el));
            chk($sformatf("vec%0d_busy", i), 32'(bsy), 32'(vecs[i].el));
        end
        @(negedge clk);
        chk("done_pulse_width", 32'(get_done(vecs[vecs.size()-1].sel)), 32'd0);

        // Asynchronous reset in the middle of an operation.
        do_op(0, 8'hFF, 8'hFF, 0, 0, 0, -1, s, co, lat, bsy);
        chk("pre_rst_sum", 32'(s), 32'hFE);
        @(negedge clk);
        drive(0, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        chk("midrst_busy", 32'(bus0.busy), 32'd0);
        chk("midrst_done", 32'(bus0.done), 32'd0);
        chk("midrst_sum",  32'(bus0.sum),  32'd0);
        chk("midrst_cout", 32'(bus0.cout), 32'd0);
        #0.5 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus0.done) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        do_op(0, 8'h0F, 8'h01, 0, 0, 0, -1, s, co, lat, bsy);
        chk("post_rst_sum", 32'(s),   32'h10);
        chk("post_rst_lat", 32'(lat), 32'd8);

        // Randomized operations on the two 8-bit instances.
        for (int i = 0; i < 150; i++) begin
            int         sel  = int'($urandom_range(1, 0));
            logic [7:0] ra   = 8'($urandom);
            logic [7:0] rb   = 8'($urandom);
            logic       rc   = 1'($urandom);
            logic       rs   = SUB_EN ? 1'($urandom) : 1'b0;
            logic       rb2b = ($urandom_range(3, 0) == 0);
            steps = (sel == 0) ? 8 : 2;
            r = model(8, ra, rb, rc, rs);
            do_op(sel, ra, rb, rc, rs, rb2b, -1, s, co, lat, bsy);
            chk($sformatf("rnd%0d_sum", i),  32'(s),   r & 32'hFF);
            chk($sformatf("rnd%0d_cout", i), 32'(co),  (r >> 8) & 32'd1);
            chk($sformatf("rnd%0d_lat", i),  32'(lat), 32'(steps));
        end

        // Exhaustive sweep of the 3-bit instance.
        for (int sb = 0; sb <= int'(SUB_EN); sb++) begin
            for (int ia = 0; ia < 8; ia++) begin
                for (int ib = 0; ib < 8; ib++) begin
                    for (int ic = 0; ic < 2; ic++) begin
                        r = model(3, 8'(ia), 8'(ib), 1'(ic), 1'(sb));
                        do_op(2, 8'(ia), 8'(ib), 1'(ic), 1'(sb), 1'b0, -1, s, co, lat, bsy);
                        chk($sformatf("w3_%0d_%0d_%0d_%0d_sum", sb, ia, ib, ic), 32'(s), r & 32'h7);
                        chk($sformatf("w3_%0d_%0d_%0d_%0d_cout", sb, ia, ib, ic), 32'(co), (r >> 3) & 32'd1);
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
